// File: rtl/universal_shift_reg_if.sv
// Universal shift register signal bundle.
// Control, data and status between a driver and the register.
interface universal_shift_reg_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             en;
   logic [1:0]       mode;
   logic             rot;
   logic [WIDTH-1:0] d;
   logic             di_r;
   logic             di_l;
   logic [WIDTH-1:0] q;
   logic             do_r;
   logic             do_l;
   logic [CW-1:0]    cnt;
   logic             done;

   modport master (
      output en, mode, rot, d, di_r, di_l,
      input  q, do_r, do_l, cnt, done
   );

   modport slave (
      input  en, mode, rot, d, di_r, di_l,
      output q, do_r, do_l, cnt, done
   );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift/rotate either way, load.
// Counts shifts since the last load, saturating at WIDTH.
module universal_shift_reg #(
   parameter int          WIDTH   = 8,
   parameter logic [31:0] RST_VAL = '0
) (
   input logic                 clk,
   input logic                 clrn,
   universal_shift_reg_if.slave bus
);
   localparam int            CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_nxt;
   logic [CW-1:0]    cnt_inc;
   logic             sin_r;
   logic             sin_l;

   // Next state: pick serial-in source, then apply the selected mode.
   always_comb begin
      sin_r   = bus.rot ? q_r[0] : bus.di_r;
      sin_l   = bus.rot ? q_r[WIDTH-1] : bus.di_l;
      cnt_inc = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CW'(1);
      q_nxt   = q_r;
      cnt_nxt = cnt_r;
      if (bus.en) begin
         unique case (bus.mode)
            2'b01: begin
               q_nxt   = {sin_r, q_r[WIDTH-1:1]};
               cnt_nxt = cnt_inc;
            end
            2'b10: begin
               q_nxt   = {q_r[WIDTH-2:0], sin_l};
               cnt_nxt = cnt_inc;
            end
            2'b11: begin
               q_nxt   = bus.d;
               cnt_nxt = '0;
            end
            default: begin
               q_nxt   = q_r;
               cnt_nxt = cnt_r;
            end
         endcase
      end
   end

   // State register with asynchronous clear to the reset pattern.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         q_r   <= RST_VAL[WIDTH-1:0];
         cnt_r <= '0;
      end else begin
         q_r   <= q_nxt;
         cnt_r <= cnt_nxt;
      end
   end

   assign bus.q    = q_r;
   assign bus.do_r = q_r[0];
   assign bus.do_l = q_r[WIDTH-1];
   assign bus.cnt  = cnt_r;
   assign bus.done = (cnt_r == CNT_MAX);
endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed table, corner sequences,
// and random traffic against a behavioural model.
module tb_universal_shift_reg;
   localparam int W = 8;

   typedef struct {
      logic       en;
      logic [1:0] mode;
      logic       rot;
      logic [7:0] d;
      logic       dir;
      logic       dil;
      logic [7:0] eq;
      int         ec;
   } vec_t;

   logic clk = 1'b0;
   logic clrn = 1'b0;
   logic clrn3 = 1'b0;
   int   nvec = 0;
   int   nmis = 0;
   int unsigned mq;
   int unsigned mc;
   vec_t tbl[$];

   always #5 clk = ~clk;

   universal_shift_reg_if #(.WIDTH(8)) b8 ();
   universal_shift_reg_if #(.WIDTH(3)) b3 ();

   universal_shift_reg #(.WIDTH(8), .RST_VAL(32'd0)) dut8 (
      .clk(clk), .clrn(clrn), .bus(b8.slave)
   );

   universal_shift_reg #(.WIDTH(3), .RST_VAL(32'd5)) dut3 (
      .clk(clk), .clrn(clrn3), .bus(b3.slave)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Behavioural model of one clock edge, in plain arithmetic.
   task automatic mstep(input logic en, input logic [1:0] mode,
                        input logic rot, input logic [7:0] d,
                        input logic dir, input logic dil);
      int unsigned inb;
      if (!en || mode == 2'd0) return;
      if (mode == 2'd3) begin
         mq = d;
         mc = 0;
         return;
      end
      if (mode == 2'd1) begin
         inb = rot ? (mq % 2) : dir;
         mq  = (mq / 2) + inb * (1 << (W - 1));
      end else begin
         inb = rot ? (mq / (1 << (W - 1))) : dil;
         mq  = (mq * 2 + inb) % (1 << W);
      end
      if (mc < W) mc = mc + 1;
   endtask

   task automatic chk_model(input string nm);
      chk({nm, ".q"}, 32'(b8.q), mq);
      chk({nm, ".cnt"}, 32'(b8.cnt), mc);
      chk({nm, ".done"}, 32'(b8.done), 32'(mc == W));
      chk({nm, ".do_r"}, 32'(b8.do_r), mq % 2);
      chk({nm, ".do_l"}, 32'(b8.do_l), mq / (1 << (W - 1)));
   endtask

   task automatic drive(input logic en, input logic [1:0] mode,
                        input logic rot, input logic [7:0] d,
                        input logic dir, input logic dil);
      b8.en   = en;
      b8.mode = mode;
      b8.rot  = rot;
      b8.d    = d;
      b8.di_r = dir;
      b8.di_l = dil;
   endtask

   function automatic vec_t mk(input logic en, input logic [1:0] mode,
                               input logic rot, input logic [7:0] d,
                               input logic dir, input logic [7:0] eq,
                               input int ec);
      vec_t v;
      v.en   = en;
      v.mode = mode;
      v.rot  = rot;
      v.d    = d;
      v.dir  = dir;
      v.dil  = 1'b1;
      v.eq   = eq;
      v.ec   = ec;
      return v;
   endfunction

   initial begin
      logic [7:0] dor_exp;
      logic [7:0] rq;
      logic       ren;
      logic [1:0] rmode;
      logic       rrot;
      logic [7:0] rd;
      logic       rdir;
      logic       rdil;

      // Load B3 then shift right 8 times with zero fill.
      tbl.push_back(mk(1, 3, 0, 8'hB3, 0, 8'hB3, 0));
      tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h59, 1));
      tbl.push_back(mk(1, 1, 0, 8'hFF, 0, 8'h2C, 2));
      tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h16, 3));
      tbl.push_back(mk(1, 1, 0, 8'hFF, 0, 8'h0B, 4));
      tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h05, 5));
      tbl.push_back(mk(1, 1, 0, 8'hFF, 0, 8'h02, 6));
      tbl.push_back(mk(1, 1, 0, 8'h00, 0, 8'h01, 7));
      tbl.push_back(mk(1, 1, 0, 8'hFF, 0, 8'h00, 8));
      // Load 81 then rotate left 3 times.
      tbl.push_back(mk(1, 3, 1, 8'h81, 1, 8'h81, 0));
      tbl.push_back(mk(1, 2, 1, 8'h00, 1, 8'h03, 1));
      tbl.push_back(mk(1, 2, 1, 8'h00, 1, 8'h06, 2));
      tbl.push_back(mk(1, 2, 1, 8'h00, 1, 8'h0C, 3));
      // Load 0F then hold with en low while mode asks to shift.
      tbl.push_back(mk(1, 3, 0, 8'h0F, 0, 8'h0F, 0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 1, 0, 8'hFF, 1, 8'h0F, 0));
      // Load 55 then rotate right 10 times: count saturates at 8.
      tbl.push_back(mk(1, 3, 0, 8'h55, 0, 8'h55, 0));
      for (int i = 1; i <= 10; i++)
         tbl.push_back(mk(1, 1, 1, 8'h00, 0,
                          (i % 2) ? 8'hAA : 8'h55, (i > 8) ? 8 : i));
      // Reload right after saturation, then mode 00 hold.
      tbl.push_back(mk(1, 3, 1, 8'hAA, 1, 8'hAA, 0));
      tbl.push_back(mk(1, 0, 1, 8'hFF, 1, 8'hAA, 0));

      drive(0, 0, 0, 8'h00, 0, 0);
      b3.en   = 1'b0;
      b3.mode = 2'd0;
      b3.rot  = 1'b0;
      b3.d    = 3'd0;
      b3.di_r = 1'b0;
      b3.di_l = 1'b0;
      mq = 0;
      mc = 0;

      #12;
      chk("rst8.q", 32'(b8.q), 0);
      chk("rst8.cnt", 32'(b8.cnt), 0);
      chk("rst8.done", 32'(b8.done), 0);
      chk("rst3.q", 32'(b3.q), 5);
      @(negedge clk);
      clrn  = 1'b1;
      clrn3 = 1'b1;

      // Directed table; do_r sampled after each edge.
      dor_exp = 8'b1011_0011;
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].en, tbl[i].mode, tbl[i].rot, tbl[i].d,
               tbl[i].dir, tbl[i].dil);
         @(posedge clk);
         #1;
         mstep(tbl[i].en, tbl[i].mode, tbl[i].rot, tbl[i].d,
               tbl[i].dir, tbl[i].dil);
         rq = tbl[i].eq;
         chk($sformatf("tbl%0d.q", i), 32'(b8.q), 32'(rq));
         chk($sformatf("tbl%0d.cnt", i), 32'(b8.cnt), tbl[i].ec);
         chk($sformatf("tbl%0d.done", i), 32'(b8.done),
             32'(tbl[i].ec == W));
         chk($sformatf("tbl%0d.do_r", i), 32'(b8.do_r), 32'(rq[0]));
         if (i < 8)
            chk($sformatf("tbl%0d.dor_seq", i), 32'(b8.do_r),
                32'(dor_exp[i]));
      end

      // Width-3 instance from reset value 101 with di_r=1.
      chk("w3.rst", 32'(b3.q), 5);
      @(negedge clk);
      b3.en   = 1'b1;
      b3.mode = 2'd1;
      b3.di_r = 1'b1;
      @(posedge clk);
      #1;
      chk("w3.s1.q", 32'(b3.q), 6);
      chk("w3.s1.cnt", 32'(b3.cnt), 1);
      @(posedge clk);
      #1;
      chk("w3.s2.q", 32'(b3.q), 7);
      chk("w3.s2.done", 32'(b3.done), 0);
      @(posedge clk);
      #1;
      chk("w3.s3.q", 32'(b3.q), 7);
      chk("w3.s3.cnt", 32'(b3.cnt), 3);
      chk("w3.s3.done", 32'(b3.done), 1);
      b3.en = 1'b0;

      // Async reset between edges, inputs ignored while held.
      @(negedge clk);
      #2;
      clrn = 1'b0;
      mq = 0;
      mc = 0;
      #1;
      chk_model("async_rst");
      drive(1, 3, 1, 8'hFF, 1, 1);
      @(posedge clk);
      #1;
      chk_model("rst_hold");
      @(negedge clk);
      clrn = 1'b1;
      drive(1, 1, 0, 8'h00, 1, 0);
      @(posedge clk);
      #1;
      mstep(1, 1, 0, 8'h00, 1, 0);
      chk("post_rst.q", 32'(b8.q), 32'h80);
      chk_model("post_rst");

      // Random traffic with occasional mid-cycle reset pulses.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         ren   = ($urandom_range(0, 7) != 0);
         rmode = 2'($urandom_range(0, 3));
         rrot  = 1'($urandom);
         rd    = 8'($urandom);
         rdir  = 1'($urandom);
         rdil  = 1'($urandom);
         drive(ren, rmode, rrot, rd, rdir, rdil);
         if ($urandom_range(0, 39) == 0) begin
            #1;
            clrn = 1'b0;
            mq = 0;
            mc = 0;
            #1;
            chk_model($sformatf("rnd%0d.rst", n));
            #1;
            clrn = 1'b1;
         end
         @(posedge clk);
         #1;
         mstep(ren, rmode, rrot, rd, rdir, rdil);
         chk_model($sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RST_VAL, default 0, value loaded into q on reset.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port clrn  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port en  input  1  clock enable; 0 holds all state.
REQ-006 The block SHALL have port mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The block SHALL have port rot  input  1  1 selects rotate instead of shift for modes 01/10.
REQ-008 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-009 The block SHALL have port di_r  input  1  serial input entering q[WIDTH-1] on shift right.
REQ-010 The block SHALL have port di_l  input  1  serial input entering q[0] on shift left.
REQ-011 The block SHALL have port q  output  WIDTH  register contents.
REQ-012 The block SHALL have port do_r  output  1  serial output, equals q[0].
REQ-013 The block SHALL have port do_l  output  1  serial output, equals q[WIDTH-1].
REQ-014 The block SHALL have port cnt  output  clog2(WIDTH+1)  shifts performed since last load, saturating.
REQ-015 The block SHALL have port done  output  1  high when cnt == WIDTH.

Function
REQ-016 With en=0, q and cnt SHALL hold regardless of mode, rot, d, or serial inputs.
REQ-017 With en=1, mode=00: q and cnt SHALL hold.
REQ-018 With en=1, mode=01, rot=0: q SHALL become {di_r, q[WIDTH-1:1]} on the next edge.
REQ-019 With en=1, mode=10, rot=0: q SHALL become {q[WIDTH-2:0], di_l} on the next edge.
REQ-020 With en=1, mode=01, rot=1: q SHALL become {q[0], q[WIDTH-1:1]}; di_r ignored.
REQ-021 With en=1, mode=10, rot=1: q SHALL become {q[WIDTH-2:0], q[WIDTH-1]}; di_l ignored.
REQ-022 With en=1, mode=11: q SHALL become d and cnt SHALL become 0 on the next edge; rot ignored.
REQ-023 Each shift or rotate with en=1 SHALL increment cnt by 1; at cnt==WIDTH it SHALL saturate and hold.
REQ-024 Shifting SHALL continue to modify q after cnt saturates; only cnt stops.
REQ-025 done SHALL be combinational from cnt (cnt==WIDTH), with no extra cycle of latency.
REQ-026 do_r and do_l SHALL be combinational from q; serial output therefore lags serial input by WIDTH edges.
REQ-027 Register latency SHALL be exactly one clock edge for every mode; no internal pipelining.

Reset
REQ-028 clrn=0 SHALL immediately, without a clock edge, force q=RST_VAL[WIDTH-1:0], cnt=0, done=0.
REQ-029 While clrn=0, all inputs including en and mode=11 SHALL be ignored.
REQ-030 Reset asserted mid-shift SHALL discard the partial shift; after clrn rises, the first rising edge SHALL operate normally from RST_VAL.

Verification
REQ-031 WIDTH=8, RST_VAL=0: clrn=0 between edges -> q=00000000, cnt=0, done=0 before the next clk edge.
REQ-032 Load d=10110011 (mode=11), then 8 cycles mode=01, rot=0, di_r=0 -> do_r sequence 1,1,0,0,1,1,0,1; final q=00000000, cnt=8, done=1.
REQ-033 Load 10000001, mode=10, rot=1, 3 cycles -> q=00001100, cnt=3, done=0.
REQ-034 Load 0x0F, then en=0 with mode=01 for 4 cycles -> q=00001111, cnt=0 unchanged.
REQ-035 Shift 10 times after a load -> cnt holds at 8 from the 8th shift on; a mode=11 load with d=0xAA on the next edge -> q=10101010, cnt=0, done=0.
REQ-036 WIDTH=3, RST_VAL=101, di_r=1, mode=01 -> q after reset is 101, then 110, then 111; cnt reaches 3, done=1.
